// File: rtl/ysyx_25040105_pkg.sv
// Shared definitions for the NPC instruction fetch unit.
package ysyx_25040105_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    // Fetch FSM: one instruction in flight from request to commit.
    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_NPC = 2'd3
    } fetch_state_e;

    // Word fetches need a 4-byte aligned PC.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25040105_reg.sv
// Enabled register with parameterised width and reset value.
module ysyx_25040105_reg #(
    parameter int unsigned      Width    = 32,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    // Load d when enabled; async reset to ResetVal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ResetVal;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction and
// presents it to decode, then waits for commit to return the next PC.
module ysyx_25040105_ifu
    import ysyx_25040105_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    input  logic            inst_ready,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] pc
);

    fetch_state_e state_q, state_d;
    // Registered request flag keeps imem_req_valid low while in reset.
    logic req_valid_q, req_valid_d;

    logic            pc_en;
    logic            cap_en;
    logic [XLEN-1:0] inst_d;
    logic            inst_err_d;

    // State and request-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Next-state and request-valid logic.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        case (state_q)
            S_REQ: begin
                if (is_misaligned(pc)) begin
                    state_d     = S_HOLD;
                    req_valid_d = 1'b0;
                end else if (req_valid_q && imem_req_ready) begin
                    state_d     = S_WAIT_RSP;
                    req_valid_d = 1'b0;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d = S_WAIT_NPC;
                end
            end
            S_WAIT_NPC: begin
                if (npc_valid) begin
                    state_d = S_REQ;
                    // Raise the request straight away so the loop stays at 4 cycles.
                    req_valid_d = !is_misaligned(npc);
                end
            end
            default: begin
                state_d     = S_REQ;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Capture enables and data for the decode-facing registers.
    always_comb begin
        pc_en      = (state_q == S_WAIT_NPC) && npc_valid;
        cap_en     = 1'b0;
        inst_d     = '0;
        inst_err_d = 1'b0;
        if (state_q == S_REQ && is_misaligned(pc)) begin
            cap_en     = 1'b1;
            inst_err_d = 1'b1;
        end else if (state_q == S_WAIT_RSP && imem_rsp_valid) begin
            cap_en     = 1'b1;
            inst_d     = imem_rsp_err ? '0 : imem_rsp_data;
            inst_err_d = imem_rsp_err;
        end
    end

    ysyx_25040105_reg #(
        .Width   (XLEN),
        .ResetVal(RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pc_en),
        .d    (npc),
        .q    (pc)
    );

    ysyx_25040105_reg #(
        .Width   (XLEN),
        .ResetVal('0)
    ) u_inst_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (cap_en),
        .d    (inst_d),
        .q    (inst)
    );

    ysyx_25040105_reg #(
        .Width   (XLEN),
        .ResetVal(RESET_PC)
    ) u_inst_pc_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (cap_en),
        .d    (pc),
        .q    (inst_pc)
    );

    ysyx_25040105_reg #(
        .Width   (1),
        .ResetVal(1'b0)
    ) u_inst_err_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (cap_en),
        .d    (inst_err_d),
        .q    (inst_err)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_q == S_HOLD);

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Self-checking bench for the fetch unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-phase model.
module tb_ysyx_25040105_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int P_FETCH = 0;
    localparam int P_RSP   = 1;
    localparam int P_HOLD  = 2;
    localparam int P_NPC   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] pc;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_25040105_ifu u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_err      (inst_err),
        .inst_ready    (inst_ready),
        .npc_valid     (npc_valid),
        .npc           (npc),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which transaction phase the one in-flight instruction
    // is in, and the record decode should see.
    int          m_phase;
    logic        m_req_vis;
    logic [31:0] m_pc, m_inst, m_inst_pc;
    logic        m_err;
    int          m_n_insts = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= P_FETCH;
            m_req_vis <= 1'b0;
            m_pc      <= RST_PC;
            m_inst    <= 32'h0;
            m_inst_pc <= RST_PC;
            m_err     <= 1'b0;
        end else begin
            case (m_phase)
                P_FETCH: begin
                    if (m_pc % 4 != 0) begin
                        m_inst    <= 32'h0;
                        m_inst_pc <= m_pc;
                        m_err     <= 1'b1;
                        m_phase   <= P_HOLD;
                        m_req_vis <= 1'b0;
                        m_n_insts <= m_n_insts + 1;
                    end else if (m_req_vis && imem_req_ready) begin
                        m_phase   <= P_RSP;
                        m_req_vis <= 1'b0;
                    end else begin
                        m_req_vis <= 1'b1;
                    end
                end
                P_RSP: begin
                    if (imem_rsp_valid) begin
                        m_inst    <= imem_rsp_err ? 32'h0 : imem_rsp_data;
                        m_inst_pc <= m_pc;
                        m_err     <= imem_rsp_err;
                        m_phase   <= P_HOLD;
                        m_n_insts <= m_n_insts + 1;
                    end
                end
                P_HOLD: if (inst_ready) m_phase <= P_NPC;
                default: begin
                    if (npc_valid) begin
                        m_pc      <= npc;
                        m_phase   <= P_FETCH;
                        m_req_vis <= (npc % 4 == 0);
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_valid", {31'h0, imem_req_valid}, {31'h0, m_req_vis});
            check("req_addr", imem_req_addr, m_pc);
            check("pc", pc, m_pc);
            check("inst_valid", {31'h0, inst_valid}, {31'h0, m_phase == P_HOLD});
            if (m_phase == P_HOLD) begin
                check("inst", inst, m_inst);
                check("inst_pc", inst_pc, m_inst_pc);
                check("inst_err", {31'h0, inst_err}, {31'h0, m_err});
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc_valid      = 1'b0;
        npc            = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_pc", pc, RST_PC);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, RST_PC);
        check("rst_inst_err", {31'h0, inst_err}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);

        // Zero-wait fetch of the first instruction.
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        rst_n          = 1'b1;
        cyc();
        check("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("t1_req_addr", imem_req_addr, RST_PC);
        cyc();
        check("t1_wait_valid", {31'h0, inst_valid}, 32'h0);
        cyc();
        check("t1_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("t1_inst", inst, 32'h0010_0093);
        check("t1_inst_pc", inst_pc, RST_PC);
        check("t1_inst_err", {31'h0, inst_err}, 32'h0);

        // Handshake, then redirect.
        idle_inputs();
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        check("t2_inst_valid", {31'h0, inst_valid}, 32'h0);
        npc_valid = 1'b1;
        npc       = 32'h8000_0100;
        cyc();
        npc_valid = 1'b0;
        check("t3_pc", pc, 32'h8000_0100);
        check("t3_req_addr", imem_req_addr, 32'h8000_0100);
        check("t3_req_valid", {31'h0, imem_req_valid}, 32'h1);

        // Request backpressure.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_req_valid", {31'h0, imem_req_valid}, 32'h1);
            check("bp_req_addr", imem_req_addr, 32'h8000_0100);
        end
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00a0_0113;
        cyc();
        // Decode backpressure with spurious npc and response traffic.
        imem_rsp_data = 32'h5555_5555;
        npc_valid     = 1'b1;
        npc           = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("bp_inst_valid", {31'h0, inst_valid}, 32'h1);
            check("bp_inst", inst, 32'h00a0_0113);
            check("bp_inst_pc", inst_pc, 32'h8000_0100);
            check("bp_no_req", {31'h0, imem_req_valid}, 32'h0);
            check("bp_pc", pc, 32'h8000_0100);
        end
        idle_inputs();

        // Misaligned redirect.
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        npc_valid  = 1'b1;
        npc        = 32'h8000_0102;
        cyc();
        npc_valid = 1'b0;
        check("mis_no_req0", {31'h0, imem_req_valid}, 32'h0);
        cyc();
        check("mis_no_req1", {31'h0, imem_req_valid}, 32'h0);
        check("mis_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("mis_inst_err", {31'h0, inst_err}, 32'h1);
        check("mis_inst", inst, 32'h0);
        check("mis_inst_pc", inst_pc, 32'h8000_0102);

        // Spurious response while a request is pending, then a bus error.
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        npc_valid  = 1'b1;
        npc        = 32'h8000_0200;
        cyc();
        npc_valid      = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        cyc();
        imem_rsp_valid = 1'b0;
        check("sp_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("sp_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("sp_pc", pc, 32'h8000_0200);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_rsp_err   = 1'b1;
        cyc();
        idle_inputs();
        check("err_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("err_inst_err", {31'h0, inst_err}, 32'h1);
        check("err_inst", inst, 32'h0);
        check("err_inst_pc", inst_pc, 32'h8000_0200);

        // Reset while waiting for a response; a late response must be ignored.
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        npc_valid  = 1'b1;
        npc        = 32'h8000_0300;
        cyc();
        npc_valid      = 1'b0;
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        rst_n          = 1'b0;
        #1;
        check("mr_pc", pc, RST_PC);
        check("mr_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("mr_req_valid", {31'h0, imem_req_valid}, 32'h0);
        cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0BAD;
        rst_n          = 1'b1;
        cyc();
        check("late_inst_valid0", {31'h0, inst_valid}, 32'h0);
        check("late_req_valid", {31'h0, imem_req_valid}, 32'h1);
        cyc();
        check("late_inst_valid1", {31'h0, inst_valid}, 32'h0);
        idle_inputs();

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 4000; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = ($urandom_range(0, 2) == 0);
            imem_rsp_data  = $urandom;
            imem_rsp_err   = ($urandom_range(0, 7) == 0);
            inst_ready     = 1'($urandom_range(0, 1));
            npc_valid      = ($urandom_range(0, 2) == 0);
            npc            = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 7) == 0) npc = npc + 32'($urandom_range(1, 3));
            cyc();
        end
        idle_inputs();
        cyc();
        check("rand_progress", {31'h0, m_n_insts > 100}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
